// File: rtl/seg7_scan_controller_if.sv
// seg7_scan_controller_if: keypad entry and 7-segment display signal bundle.
//   bcd_in[3:0]      keypad digit, qualified by key_valid
//   key_valid        single-cycle strobe for bcd_in
//   clear            synchronous buffer clear
//   seg[6:0]         active-high segments, bit 0 = a .. bit 6 = g
//   an[5:0]          one-hot digit enable, bit 0 = rightmost digit
//   digit_count[2:0] digits entered, 0..6
//   full             digit_count == 6
//   bad_key          one-cycle pulse after a strobe carrying a non-BCD value
// master drives the keypad side, slave is the controller.
interface seg7_scan_controller_if;
    logic [3:0] bcd_in;
    logic       key_valid;
    logic       clear;
    logic [6:0] seg;
    logic [5:0] an;
    logic [2:0] digit_count;
    logic       full;
    logic       bad_key;
    modport master (output bcd_in, key_valid, clear, input seg, an, digit_count, full, bad_key);
    modport slave  (input bcd_in, key_valid, clear, output seg, an, digit_count, full, bad_key);
endinterface

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: six-digit BCD entry buffer multiplexed onto a shared 7-segment bus.
//   clk, rst  system clock, synchronous active-high reset
//   bus       seg7_scan_controller_if.slave: keypad inputs, display and status outputs
//   SCAN_DIV  clock cycles per digit slot (>= 2); the last cycle of each slot is blanked
// Optional feature: define SEG7_LEADING_BLANK_EN to darken positions not yet entered.
module seg7_scan_controller #(
    parameter int SCAN_DIV = 50000
) (
    input  logic                         clk,
    input  logic                         rst,
    seg7_scan_controller_if.slave        bus
);
    localparam int DIGITS = 6;
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

    logic [DIGITS-1:0][3:0] dbuf_q, dbuf_d;
    logic [PW-1:0]          pcnt_q, pcnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [6:0]             seg_q, seg_d;
    logic [5:0]             an_q, an_d;
    logic                   bad_q, bad_d;
    logic                   blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1100111;
            default: decode = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        blank  = pcnt_q == LAST;
        pcnt_d = blank ? '0 : pcnt_q + 1'b1;
        idx_d  = blank ? ((idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1) : idx_q;
        dbuf_d = dbuf_q;
        cnt_d  = cnt_q;
        // clear wins over a simultaneous strobe and suppresses its bad_key
        if (bus.clear) begin
            dbuf_d = '0;
            cnt_d  = '0;
        end else if (bus.key_valid && bus.bcd_in <= 4'd9) begin
            dbuf_d = {dbuf_q[DIGITS-2:0], bus.bcd_in};
            cnt_d  = (cnt_q == 3'd6) ? cnt_q : cnt_q + 3'd1;
        end
        bad_d = bus.key_valid && !bus.clear && bus.bcd_in > 4'd9;
        an_d  = blank ? '0 : 6'b1 << idx_q;
`ifdef SEG7_LEADING_BLANK_EN
        seg_d = (blank || idx_q >= cnt_q) ? '0 : decode(dbuf_q[idx_q]);
`else
        seg_d = blank ? '0 : decode(dbuf_q[idx_q]);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dbuf_q <= '0;
            pcnt_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            seg_q  <= '0;
            an_q   <= '0;
            bad_q  <= 1'b0;
        end else begin
            dbuf_q <= dbuf_d;
            pcnt_q <= pcnt_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            bad_q  <= bad_d;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.an          = an_q;
    assign bus.digit_count = cnt_q;
    assign bus.full        = cnt_q == 3'd6;
    assign bus.bad_key     = bad_q;
endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb_seg7_scan_controller: randomized scoreboard bench for seg7_scan_controller.
module tb_seg7_scan_controller;
    localparam int D = 4;

    typedef struct {
        logic [5:0] an;
        logic [6:0] seg;
        logic [2:0] cnt;
        logic       full;
        logic       bad;
    } exp_t;

    logic clk = 0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    int digits[6];
    int cnt;
    int tick;
    logic [6:0] lut[10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                            7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1100111};

    seg7_scan_controller_if bus();
    seg7_scan_controller #(.SCAN_DIV(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Drives one clock cycle and records what the display must show afterwards.
    task automatic step(input logic r, input logic kv, input logic [3:0] d, input logic clr);
        exp_t e;
        int p, i;
        @(negedge clk);
        rst = r;
        bus.key_valid = kv;
        bus.bcd_in = d;
        bus.clear = clr;
        if (r) begin
            e = '{an: '0, seg: '0, cnt: '0, full: 1'b0, bad: 1'b0};
            foreach (digits[k]) digits[k] = 0;
            cnt = 0;
            tick = 0;
        end else begin
            p = tick % D;
            i = (tick / D) % 6;
            e.an = (p == D - 1) ? 6'd0 : 6'(1 << i);
`ifdef SEG7_LEADING_BLANK_EN
            e.seg = (p == D - 1 || i >= cnt) ? 7'd0 : lut[digits[i]];
`else
            e.seg = (p == D - 1) ? 7'd0 : lut[digits[i]];
`endif
            if (clr) begin
                foreach (digits[k]) digits[k] = 0;
                cnt = 0;
            end else if (kv && d <= 9) begin
                for (int k = 5; k > 0; k--) digits[k] = digits[k-1];
                digits[0] = int'(d);
                if (cnt < 6) cnt++;
            end
            e.cnt = 3'(cnt);
            e.full = cnt == 6;
            e.bad = kv && !clr && d > 9;
            tick++;
        end
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("an", int'(bus.an), int'(e.an));
            chk("seg", int'(bus.seg), int'(e.seg));
            chk("digit_count", int'(bus.digit_count), int'(e.cnt));
            chk("full", int'(bus.full), int'(e.full));
            chk("bad_key", int'(bus.bad_key), int'(e.bad));
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.key_valid = 1'b0;
        bus.bcd_in = '0;
        bus.clear = 1'b0;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 4'd0, 1'b0);
        idle(6 * D);
        for (int k = 1; k <= 3; k++) step(1'b0, 1'b1, 4'(k), 1'b0);
        idle(6 * D);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        for (int k = 1; k <= 7; k++) step(1'b0, 1'b1, 4'(k), 1'b0);
        idle(6 * D);
        step(1'b0, 1'b1, 4'hC, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 4'd5, 1'b1);
        idle(6 * D);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 4'(k + 6), 1'b0);
        for (int k = 0; k < 6 * D && (tick / D) % 6 != 3; k++) idle(1);
        idle(1);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        idle(2 * D);
        for (int k = 0; k < 600; k++) begin
            logic r, kv, clr;
            r   = $urandom_range(0, 199) == 0;
            kv  = $urandom_range(0, 2) == 0;
            clr = $urandom_range(0, 39) == 0;
            step(r, kv, 4'($urandom_range(0, 15)), clr);
        end
        idle(2);
        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
